hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_if.sv | 27 ++
 rtl/hazard_ctrl.sv | 95 +++++++++
 tb/tb_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller signal bundle: pipeline hazard inputs and PC/IF-ID/ID-EX controls.
// The master side sources hazard inputs; the slave side (hazard_ctrl) drives the pipeline controls.
interface hazard_if;
   logic        IDEXMemRead;
   logic [4:0]  IDEXrd;
   logic [4:0]  IFIDrs1;
   logic [4:0]  IFIDrs2;
   logic        Branch_taken;
   logic        JALR_taken;
   logic        pc_write;
   logic        IFID_write;
   logic        IFID_flush;
   logic        IDEX_flush;
   logic        busy;
   logic [15:0] stall_count;
   logic [15:0] redirect_count;

   modport master (
      output IDEXMemRead, IDEXrd, IFIDrs1, IFIDrs2, Branch_taken, JALR_taken,
      input  pc_write, IFID_write, IFID_flush, IDEX_flush, busy, stall_count, redirect_count
   );

   modport slave (
      input  IDEXMemRead, IDEXrd, IFIDrs1, IFIDrs2, Branch_taken, JALR_taken,
      output pc_write, IFID_write, IFID_flush, IDEX_flush, busy, stall_count, redirect_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall / redirect flush controller; controls are combinational, same cycle as inputs.
// No backpressure: redirect outranks a load-use hazard, and a hazard is only sampled in RUN.
module hazard_ctrl #(
   parameter int LOAD_BUBBLES     = 1,
   parameter int REDIRECT_BUBBLES = 1
) (
   input  logic   clk,
   input  logic   reset,
   hazard_if.slave hif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      RFLUSH = 2'd2
   } state_t;

   localparam logic [2:0] LOAD_CNT     = 3'(LOAD_BUBBLES - 1);
   localparam logic [2:0] REDIRECT_CNT = 3'(REDIRECT_BUBBLES - 1);

   state_t     state;
   logic [2:0] cnt;
   logic       redirect;
   logic       hazard;

   assign redirect = hif.Branch_taken | hif.JALR_taken;
   assign hazard   = hif.IDEXMemRead && (hif.IDEXrd != 5'd0) &&
                     ((hif.IDEXrd == hif.IFIDrs1) || (hif.IDEXrd == hif.IFIDrs2));

   assign hif.busy = (state != RUN);

   always_comb begin
      hif.pc_write   = 1'b1;
      hif.IFID_write = 1'b1;
      hif.IFID_flush = 1'b0;
      hif.IDEX_flush = 1'b0;
      if (reset) begin
         hif.pc_write   = 1'b0;
         hif.IFID_write = 1'b0;
         hif.IFID_flush = 1'b1;
         hif.IDEX_flush = 1'b1;
      end else if (redirect || state == RFLUSH) begin
         hif.IFID_flush = 1'b1;
         hif.IDEX_flush = 1'b1;
      end else if (state == LSTALL || hazard) begin
         // Freeze PC and IF/ID, bubble ID/EX until the load result is forwardable
         hif.pc_write   = 1'b0;
         hif.IFID_write = 1'b0;
         hif.IDEX_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= RUN;
         cnt                <= 3'd0;
         hif.stall_count    <= 16'd0;
         hif.redirect_count <= 16'd0;
      end else begin
         if (redirect) begin
            if (hif.redirect_count != 16'hFFFF)
               hif.redirect_count <= hif.redirect_count + 16'd1;
            if (REDIRECT_BUBBLES > 1) begin
               state <= RFLUSH;
               cnt   <= REDIRECT_CNT;
            end else begin
               state <= RUN;
               cnt   <= 3'd0;
            end
         end else begin
            case (state)
               RUN: begin
                  if (hazard && LOAD_BUBBLES > 1) begin
                     state <= LSTALL;
                     cnt   <= LOAD_CNT;
                  end
               end
               LSTALL, RFLUSH: begin
                  cnt <= cnt - 3'd1;
                  if (cnt == 3'd1)
                     state <= RUN;
               end
               default: begin
                  state <= RUN;
                  cnt   <= 3'd0;
               end
            endcase
         end

         if (!hif.pc_write && hif.stall_count != 16'hFFFF)
            hif.stall_count <= hif.stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations share one stimulus stream and are each checked
// against a cycle-window reference model, plus a vector table and hand-written corner sequences.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       mr;
   logic [4:0] rd, rs1, rs2;
   logic       br, jl;

   always #5 clk = ~clk;

   hazard_if ifa ();
   hazard_if ifb ();
   hazard_if ifc ();

   hazard_ctrl #(.LOAD_BUBBLES(1), .REDIRECT_BUBBLES(1)) dut_a (.clk(clk), .reset(reset), .hif(ifa));
   hazard_ctrl #(.LOAD_BUBBLES(3), .REDIRECT_BUBBLES(1)) dut_b (.clk(clk), .reset(reset), .hif(ifb));
   hazard_ctrl #(.LOAD_BUBBLES(4), .REDIRECT_BUBBLES(2)) dut_c (.clk(clk), .reset(reset), .hif(ifc));

   assign ifa.IDEXMemRead = mr;  assign ifa.IDEXrd = rd;  assign ifa.IFIDrs1 = rs1;
   assign ifa.IFIDrs2 = rs2;     assign ifa.Branch_taken = br;  assign ifa.JALR_taken = jl;
   assign ifb.IDEXMemRead = mr;  assign ifb.IDEXrd = rd;  assign ifb.IFIDrs1 = rs1;
   assign ifb.IFIDrs2 = rs2;     assign ifb.Branch_taken = br;  assign ifb.JALR_taken = jl;
   assign ifc.IDEXMemRead = mr;  assign ifc.IDEXrd = rd;  assign ifc.IFIDrs1 = rs1;
   assign ifc.IFIDrs2 = rs2;     assign ifc.Branch_taken = br;  assign ifc.JALR_taken = jl;

   // {pc_write, IFID_write, IFID_flush, IDEX_flush}
   logic [3:0]  ctl   [3];
   logic        busy_o[3];
   logic [15:0] sc_o  [3];
   logic [15:0] rc_o  [3];

   assign ctl[0] = {ifa.pc_write, ifa.IFID_write, ifa.IFID_flush, ifa.IDEX_flush};
   assign ctl[1] = {ifb.pc_write, ifb.IFID_write, ifb.IFID_flush, ifb.IDEX_flush};
   assign ctl[2] = {ifc.pc_write, ifc.IFID_write, ifc.IFID_flush, ifc.IDEX_flush};
   assign busy_o[0] = ifa.busy;  assign sc_o[0] = ifa.stall_count;  assign rc_o[0] = ifa.redirect_count;
   assign busy_o[1] = ifb.busy;  assign sc_o[1] = ifb.stall_count;  assign rc_o[1] = ifb.redirect_count;
   assign busy_o[2] = ifc.busy;  assign sc_o[2] = ifc.stall_count;  assign rc_o[2] = ifc.redirect_count;

   localparam logic [3:0] C_RUN   = 4'b1100;
   localparam logic [3:0] C_STALL = 4'b0001;
   localparam logic [3:0] C_FLUSH = 4'b1111;
   localparam logic [3:0] C_RST   = 4'b0011;

   int errors = 0;
   int checks = 0;

   // Reference model: each instance tracks the absolute cycle at which its current
   // stall window and flush window end; the cycle number t advances once per step.
   int lb_p[3] = '{1, 3, 4};
   int rb_p[3] = '{1, 1, 2};
   int t = 0;
   int s_end[3];
   int f_end[3];
   int m_sc[3];
   int m_rc[3];

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d at t=%0d: got %0h expected %0h", name, i, t, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         s_end[i] = 0; f_end[i] = 0; m_sc[i] = 0; m_rc[i] = 0;
      end
   endtask

   task automatic model(input bit do_chk);
      logic [3:0] e;
      bit         e_busy, redir, haz;
      redir = br | jl;
      haz   = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            model_reset();
            e = C_RST;
            e_busy = 1'b0;
         end else begin
            e_busy = (t < f_end[i]) || (t < s_end[i]);
            if (redir)            e = C_FLUSH;
            else if (t < f_end[i]) e = C_FLUSH;
            else if (t < s_end[i]) e = C_STALL;
            else if (haz)          e = C_STALL;
            else                   e = C_RUN;
         end
         if (do_chk) begin
            chk("ctl",   i, 32'(ctl[i]),    32'(e));
            chk("busy",  i, 32'(busy_o[i]), 32'(e_busy));
            chk("stall_count",    i, 32'(sc_o[i]), 32'(m_sc[i]));
            chk("redirect_count", i, 32'(rc_o[i]), 32'(m_rc[i]));
         end
         if (!reset) begin
            if (redir) begin
               if (m_rc[i] < 65535) m_rc[i]++;
               f_end[i] = t + rb_p[i];
               s_end[i] = 0;
            end else if (t >= f_end[i] && t >= s_end[i] && haz) begin
               s_end[i] = t + lb_p[i];
            end
            if (e[3] == 1'b0 && m_sc[i] < 65535) m_sc[i]++;
         end
      end
      t++;
   endtask

   task automatic step(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic b, input logic j, input bit do_chk);
      @(negedge clk);
      reset = r; mr = m; rd = d; rs1 = s1; rs2 = s2; br = b; jl = j;
      #1;
      model(do_chk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic load_use();
      step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
   endtask

   typedef struct {
      logic       m;
      logic [4:0] d, s1, s2;
      logic       b, j;
      logic [3:0] e;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, C_RUN};
      tbl[1]  = '{1'b1, 5'd5,  5'd0, 5'd5,  1'b0, 1'b0, C_STALL};
      tbl[2]  = '{1'b1, 5'd7,  5'd7, 5'd3,  1'b0, 1'b0, C_STALL};
      tbl[3]  = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, C_RUN};
      tbl[4]  = '{1'b0, 5'd5,  5'd5, 5'd5,  1'b0, 1'b0, C_RUN};
      tbl[5]  = '{1'b1, 5'd4,  5'd3, 5'd2,  1'b0, 1'b0, C_RUN};
      tbl[6]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, C_FLUSH};
      tbl[7]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, C_FLUSH};
      tbl[8]  = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b1, 1'b0, C_FLUSH};
      tbl[9]  = '{1'b0, 5'd9,  5'd1, 5'd1,  1'b1, 1'b1, C_FLUSH};
      tbl[10] = '{1'b1, 5'd31, 5'd2, 5'd31, 1'b0, 1'b0, C_STALL};

      reset = 1'b1; mr = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; br = 1'b0; jl = 1'b0;
      model_reset();

      // Reset held: controls forced regardless of inputs
      step(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);

      // Single load-use: one bubble on dut_a, three on dut_b, four on dut_c
      load_use();
      chk("b_stall1", 1, 32'(ctl[1]), 32'(C_STALL));
      chk("b_busy1",  1, 32'(busy_o[1]), 32'd0);
      idle();
      chk("a_sc_one", 0, 32'(sc_o[0]), 32'd1);
      chk("a_free",   0, 32'(ctl[0]), 32'(C_RUN));
      chk("b_stall2", 1, 32'(ctl[1]), 32'(C_STALL));
      chk("b_busy2",  1, 32'(busy_o[1]), 32'd1);
      idle();
      chk("b_stall3", 1, 32'(ctl[1]), 32'(C_STALL));
      chk("b_busy3",  1, 32'(busy_o[1]), 32'd1);
      idle();
      chk("b_run",    1, 32'(ctl[1]), 32'(C_RUN));
      chk("b_busy4",  1, 32'(busy_o[1]), 32'd0);
      chk("b_sc3",    1, 32'(sc_o[1]), 32'd3);
      idle();
      idle();

      // Redirect aborting an active load stall on dut_c
      load_use();
      idle();
      chk("c_in_stall", 2, 32'(ctl[2]), 32'(C_STALL));
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      chk("c_abort",    2, 32'(ctl[2]), 32'(C_FLUSH));
      idle();
      chk("c_rflush",   2, 32'(ctl[2]), 32'(C_FLUSH));
      chk("c_rf_busy",  2, 32'(busy_o[2]), 32'd1);
      idle();
      chk("c_run",      2, 32'(ctl[2]), 32'(C_RUN));
      chk("c_rc1",      2, 32'(rc_o[2]), 32'd1);

      for (int k = 0; k < 11; k++) begin
         step(1'b0, tbl[k].m, tbl[k].d, tbl[k].s1, tbl[k].s2, tbl[k].b, tbl[k].j, 1'b1);
         chk($sformatf("tbl%0d", k), 0, 32'(ctl[0]), 32'(tbl[k].e));
      end

      for (int k = 0; k < 500; k++) begin
         step(($urandom_range(0, 59) == 0),
              1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 9) == 0), 1'b1);
      end
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a dut_c redirect flush window
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      br = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("arst_ctl",  i, 32'(ctl[i]),    32'(C_RST));
         chk("arst_busy", i, 32'(busy_o[i]), 32'd0);
         chk("arst_sc",   i, 32'(sc_o[i]),   32'd0);
         chk("arst_rc",   i, 32'(rc_o[i]),   32'd0);
      end
      model_reset();
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      load_use();
      idle();

      // Saturation: a hazard held continuously stalls every cycle on every instance
      for (int k = 0; k < 65540; k++)
         step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
      chk("sat_sc", 0, 32'(sc_o[0]), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
